alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-005 SHALL have port in_ready  output  1  unit accepts the operation this cycle.
REQ-006 SHALL have port alu_ctrl  input  4  operation code (encoding in REQ-012).
REQ-007 SHALL have ports src_a, src_b, pc  input  XLEN each  operand A, operand B or immediate, instruction PC.
REQ-008 SHALL have port flush  input  1  synchronous kill of in-flight and held results.
REQ-009 SHALL have ports out_valid  output  1  and out_ready  input  1  result handshake.
REQ-010 SHALL have ports result  output  XLEN  and zero  output  1  (result == 0).
REQ-011 SHALL have port busy  output  1  high while a shift iterates.

Function
REQ-012 SHALL decode alu_ctrl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SRL, 0110 SRA, 0111 SLL, 1000 SLT, 1001 SLTU, 1010 AUIPC (pc+src_b), 1011 LUI (src_b); 1100-1111 SHALL execute as ADD.
REQ-013 SHALL accept an operation on a cycle where in_valid && in_ready (transfer).
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 SHALL, for non-shift ops, compute the result combinationally, register it at transfer, and go IDLE->DONE (out_valid high the next cycle, latency 1).
REQ-016 SHALL, for SRL/SRA/SLL, take shamt = src_b[4:0], load src_a into a shift register and a 5-bit counter with shamt, and go to SHIFT; shamt==0 SHALL go directly to DONE with result src_a.
REQ-017 SHALL in SHIFT shift one bit per cycle (SRA replicates bit XLEN-1, SRL/SLL fill 0), decrement counter, and go to DONE on the cycle the counter reaches 0; total latency shamt+1 cycles.
REQ-018 SHALL use two's-complement signed compare for SLT and unsigned compare for SLTU, producing 0 or 1 zero-extended to XLEN; ADD/SUB/AUIPC SHALL wrap modulo 2^XLEN.
REQ-019 SHALL drive out_valid high only in DONE and hold result, zero stable while out_valid && !out_ready.
REQ-020 SHALL leave DONE on out_valid && out_ready: to IDLE, or directly accept a new operation the same cycle (back-to-back, no bubble).
REQ-021 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), and in_ready = 0 in SHIFT and while flush is high.
REQ-022 SHALL, when flush is high, return to IDLE next cycle, drop out_valid, and accept no operation that cycle; flush SHALL override any simultaneous transfer on either side.
REQ-023 SHALL drive busy = (state==SHIFT).

Reset
REQ-024 SHALL on rst_n low immediately set state IDLE, out_valid 0, result 0, zero 1, busy 0, counter 0, regardless of operation in progress.
REQ-025 SHALL drive in_ready 1 from the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL take the alu_ctrl code constants and FSM state enum from shared package alu_pkg, also used by the ALU decoder.
REQ-027 SHALL contain one sub-module, iter_shifter (shift register, counter, done flag); all other logic SHALL be in alu_exec_unit.

Verification
REQ-028 SHALL check ADD: src_a=0x7FFFFFFF, src_b=1 -> result 0x80000000, out_valid one cycle after transfer; SUB 5-5 -> result 0, zero=1.
REQ-029 SHALL check SRA: src_a=0x80000000, src_b=4 -> busy 4 cycles, result 0xF8000000 at cycle 5; shamt 0 -> result src_a at cycle 1.
REQ-030 SHALL check SLT/SLTU with src_a=0xFFFFFFFF, src_b=1 -> SLT 1, SLTU 0; LUI src_b=0x12345000 -> 0x12345000; AUIPC pc=0x100, src_b=0x1000 -> 0x1100.
REQ-031 SHALL check backpressure: out_ready held 0 for 3 cycles -> result stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same cycle, next result following cycle.
REQ-032 SHALL check flush during SHIFT (SLL by 20, flush at cycle 3) -> IDLE next cycle, out_valid never asserted for that op.
REQ-033 SHALL check rst_n asserted mid-shift -> out_valid 0, busy 0, result 0 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and shift-mode definitions for the ALU execution unit.
package alu_pkg;

  // Shift amounts are always taken from the low five bits of operand B.
  localparam int unsigned ShamtW = 5;

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpSub   = 4'b0001,
    OpAnd   = 4'b0010,
    OpOr    = 4'b0011,
    OpXor   = 4'b0100,
    OpSrl   = 4'b0101,
    OpSra   = 4'b0110,
    OpSll   = 4'b0111,
    OpSlt   = 4'b1000,
    OpSltu  = 4'b1001,
    OpAuipc = 4'b1010,
    OpLui   = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ShSrl,
    ShSra,
    ShSll
  } shift_mode_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OpSrl) || (op == OpSra) || (op == OpSll);
  endfunction

  function automatic shift_mode_e shift_mode(input logic [3:0] op);
    case (op)
      OpSra:   return ShSra;
      OpSll:   return ShSll;
      default: return ShSrl;
    endcase
  endfunction

endpackage

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: shift register, down-counter and last-step flag.
module iter_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_en,
  input  shift_mode_e       i_mode,
  input  logic [XLEN-1:0]   i_data,
  input  logic [ShamtW-1:0] i_shamt,
  output logic [XLEN-1:0]   o_next,
  output logic              o_done
);

  logic [XLEN-1:0]   r_data;
  logic [ShamtW-1:0] r_count;
  shift_mode_e       r_mode;
  logic [XLEN-1:0]   w_next;

  // Value of the shift register after one more step in the latched mode.
  always_comb begin
    w_next = {1'b0, r_data[XLEN-1:1]};
    case (r_mode)
      ShSra:   w_next = {r_data[XLEN-1], r_data[XLEN-1:1]};
      ShSll:   w_next = {r_data[XLEN-2:0], 1'b0};
      default: w_next = {1'b0, r_data[XLEN-1:1]};
    endcase
  end

  // Load on start, then shift and count down while enabled; flush abandons the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
      r_mode  <= ShSrl;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_count <= i_shamt;
      r_mode  <= i_mode;
    end else if (i_en && (r_count != '0)) begin
      r_data  <= w_next;
      r_count <= r_count - ShamtW'(1);
    end
  end

  assign o_next = w_next;
  // High on the step that brings the counter to zero.
  assign o_done = (r_count == ShamtW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit with valid/ready handshakes and an iterative shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  state_e            r_state;
  logic              r_out_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_result;

  logic              w_transfer;
  logic              w_shift_start;
  logic              w_shift_done;
  logic [ShamtW-1:0] w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_shift_next;

  assign in_ready      = !flush &&
                         ((r_state == StIdle) || ((r_state == StDone) && out_ready));
  assign w_transfer    = in_valid && in_ready;
  assign w_shamt       = src_b[ShamtW-1:0];
  assign w_shift_start = w_transfer && is_shift_op(alu_ctrl) && (w_shamt != '0);

  // Single-cycle result; shifts pass src_a through so a zero shift completes here.
  always_comb begin
    w_alu = src_a + src_b;
    case (alu_ctrl)
      OpSub:               w_alu = src_a - src_b;
      OpAnd:               w_alu = src_a & src_b;
      OpOr:                w_alu = src_a | src_b;
      OpXor:               w_alu = src_a ^ src_b;
      OpSrl, OpSra, OpSll: w_alu = src_a;
      OpSlt:               w_alu = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OpSltu:              w_alu = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OpAuipc:             w_alu = pc + src_b;
      OpLui:               w_alu = src_b;
      default:             w_alu = src_a + src_b;
    endcase
  end

  iter_shifter #(
    .XLEN (XLEN)
  ) u_iter_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_shift_start),
    .i_flush (flush),
    .i_en    (r_state == StShift),
    .i_mode  (shift_mode(alu_ctrl)),
    .i_data  (src_a),
    .i_shamt (w_shamt),
    .o_next  (w_shift_next),
    .o_done  (w_shift_done)
  );

  // Control FSM with registered out_valid, busy and result; flush wins over any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
    end else if (flush) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_transfer) begin
            if (w_shift_start) begin
              r_state     <= StShift;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
              r_result    <= w_alu;
            end
          end else if ((r_state == StDone) && out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        StShift: begin
          if (w_shift_done) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_result    <= w_shift_next;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes expected results, monitor pops on output.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  alu_exec_unit #(
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out actual=%h required=no_output", result);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sb_result", result, mon_exp);
        chk("sb_zero", 32'(zero), 32'(mon_exp == 32'h0));
      end
    end
  end

  // Issue one op, then measure cycles to out_valid and cycles spent busy.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] e,
                        input int lat_exp, input int busy_exp);
    int lat;
    int nb;
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    pc       = p;
    exp_q.push_back(e);
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end while (!out_valid && lat < 64);
    chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({name, "_busy_cycles"}, 32'(nb), 32'(busy_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    // Reset state, observed while reset is held.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: name, op, a, b, pc, expected, latency, busy cycles.
    run_op("add_ovf",  OpAdd,   32'h7FFF_FFFF, 32'h1,         32'h0,   32'h8000_0000, 1, 0);
    run_op("sub_zero", OpSub,   32'h5,         32'h5,         32'h0,   32'h0,         1, 0);
    run_op("sub_wrap", OpSub,   32'h0,         32'h1,         32'h0,   32'hFFFF_FFFF, 1, 0);
    run_op("sra4",     OpSra,   32'h8000_0000, 32'h4,         32'h0,   32'hF800_0000, 5, 4);
    run_op("sra0",     OpSra,   32'h8000_0000, 32'h20,        32'h0,   32'h8000_0000, 1, 0);
    run_op("srl8",     OpSrl,   32'hF000_0000, 32'h8,         32'h0,   32'h00F0_0000, 9, 8);
    run_op("sll31",    OpSll,   32'h1,         32'h1F,        32'h0,   32'h8000_0000, 32, 31);
    run_op("sll1",     OpSll,   32'h3,         32'h1,         32'h0,   32'h6,         2, 1);
    run_op("slt",      OpSlt,   32'hFFFF_FFFF, 32'h1,         32'h0,   32'h1,         1, 0);
    run_op("sltu",     OpSltu,  32'hFFFF_FFFF, 32'h1,         32'h0,   32'h0,         1, 0);
    run_op("lui",      OpLui,   32'hDEAD_BEEF, 32'h1234_5000, 32'h0,   32'h1234_5000, 1, 0);
    run_op("auipc",    OpAuipc, 32'h0,         32'h1000,      32'h100, 32'h1100,      1, 0);
    run_op("and",      OpAnd,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,   32'h0F00_0F00, 1, 0);
    run_op("or",       OpOr,    32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,   32'hFF0F_FF0F, 1, 0);
    run_op("xor",      OpXor,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,   32'hF00F_F00F, 1, 0);
    run_op("op_f_add", 4'hF,    32'h2,         32'h3,         32'h0,   32'h5,         1, 0);
    run_op("op_c_add", 4'hC,    32'hFFFF_FFFF, 32'h1,         32'h0,   32'h0,         1, 0);

    // Backpressure: hold the result for three cycles, then back-to-back accept.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = OpAdd;
    src_a     = 32'd10;
    src_b     = 32'd20;
    exp_q.push_back(32'd30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = OpSub;
    src_a     = 32'd100;
    src_b     = 32'd1;
    exp_q.push_back(32'd99);
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", 32'(out_valid), 32'd1);

    // Flush in the third cycle of SLL by 20; nothing from it may appear.
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_ctrl = OpSll;
    src_a    = 32'h1;
    src_b    = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fl_busy_before", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = OpAdd;
    src_a    = 32'd7;
    src_b    = 32'd8;
    @(negedge clk);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_busy_after", 32'(busy), 32'd0);
    chk("fl_idle_in_ready", 32'(in_ready), 32'd1);
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("fl_no_out_valid", 32'(nv), 32'd0);
    run_op("after_flush", OpAdd, 32'h1, 32'h1, 32'h0, 32'h2, 1, 0);

    // Asynchronous reset in the middle of a shift, checked between clock edges.
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_ctrl = OpSra;
    src_a    = 32'h8000_0000;
    src_b    = 32'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_result", result, 32'h0);
    chk("rs_zero", 32'(zero), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    run_op("after_reset", OpXor, 32'h0000_00FF, 32'h0000_000F, 32'h0, 32'h0000_00F0, 1, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
